fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller that drives the ALU operand-source selects (forwardA/forwardB) into the EX stage.
- Decides forwarding one stage early (in ID) and registers the select codes, so they are stable for the whole EX cycle.
- Detects load-use hazards and inserts a stall plus bubble.
- Sequences multi-cycle EX operations (mul/div) with a countdown FSM.
- Handles branch flush.

Parameters:
- MC_LATENCY, 4, total EX cycles for a multi-cycle op (legal range 2..16).
- CNT_W, 4, width of the multi-cycle countdown counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ID_rs1  in  5  rs1 of the instruction in ID.
- ID_rs2  in  5  rs2 of the instruction in ID.
- ID_useRs1  in  1  ID instruction reads rs1.
- ID_useRs2  in  1  ID instruction reads rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_regWrite  in  1  EX instruction writes rd.
- EX_memRead  in  1  EX instruction is a load.
- EX_multiCycle  in  1  EX instruction is a multi-cycle op.
- MEM_rd  in  5  destination register of the instruction in MEM.
- MEM_regWrite  in  1  MEM instruction writes rd.
- branchTaken  in  1  branch/jump resolved taken in EX.
- forwardA  out  2  registered operand-A select: 0 regfile, 1 WB dataD, 2 MEM aluResult.
- forwardB  out  2  registered operand-B select; same encoding as forwardA.
- stall  out  1  freeze PC and IF/ID register.
- bubble  out  1  load zeroed control signals into ID/EX.
- exHold  out  1  freeze ID/EX and EX/MEM registers (multi-cycle op in progress).
- flush  out  1  squash IF/ID and ID/EX.

Behaviour:
- Reset:
  - state = IDLE, counter = 0, forwardA = forwardB = 0.
  - stall, bubble, exHold and flush all evaluate to 0 while reset is high.
- Match definition:
  - matchEX(rs) = EX_regWrite & (EX_rd != 0) & (EX_rd == rs).
  - matchMEM(rs) = MEM_regWrite & (MEM_rd != 0) & (MEM_rd == rs).
  - Register x0 never forwards.
- Next-select computation for each operand, in priority order:
  - use & matchEX → 2 (the producer will be in MEM next cycle).
  - else use & matchMEM → 1 (the producer will be in WB next cycle).
  - else → 0.
  - When both match, the EX (younger) producer wins.
- Load-use hazard:
  - loadUse = EX_memRead & ((ID_useRs1 & matchEX(ID_rs1)) | (ID_useRs2 & matchEX(ID_rs2))).
- States: IDLE, MC_BUSY.
- IDLE, evaluated in priority order:
  1. branchTaken:
     - flush = 1, stall = 0, bubble = 0.
     - forward registers ← 0.
     - loadUse is ignored (the ID instruction is squashed).
  2. EX_multiCycle:
     - state → MC_BUSY, counter ← MC_LATENCY-1.
     - exHold = 1, stall = 1.
     - forward registers hold.
  3. loadUse:
     - stall = 1, bubble = 1 (combinational, same cycle).
     - forward registers ← 0 (a bubble enters EX).
     - Next cycle the load is in MEM, so re-evaluation yields select 1: the stall lasts exactly 1 cycle.
  4. Otherwise: forward registers ← next-select values; all control outputs 0.
- MC_BUSY:
  - exHold = 1, stall = 1; forward registers hold.
  - counter decrements each cycle.
  - When counter == 1: exHold and stall deassert the following cycle; state → IDLE.
  - Total EX occupancy is exactly MC_LATENCY cycles.
  - branchTaken is ignored in this state (no branch can be in EX).
- Reset asserted mid-MC_BUSY: returns to IDLE next edge and clears the counter; no residual stall.
- Latency: forward selects appear 1 cycle after the ID inputs that produced them. stall, bubble and flush are combinational from current inputs and state.

Optional Feature:
- Macro: FWD_STALL_COUNT_EN.
- Defined:
  - Adds output port stallCount (32 bit).
  - Counts every cycle with stall = 1; saturates at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ALU ops, "add x5" in EX then ID reads rs1 = x5 → forwardA = 2 next cycle; stall = 0.
- x5 written in MEM, ID reads rs2 = x5, EX rd = x6 → forwardB = 1 next cycle.
- x5 written by both EX and MEM → forwardA = 2 (EX wins).
- EX rd = x0 with regWrite → forwardA = 0.
- Load-use: lw x7 in EX, ID reads x7 → stall = bubble = 1 for exactly 1 cycle, then forwardA = 1; with FWD_STALL_COUNT_EN, stallCount = 1.
- Multi-cycle: EX_multiCycle pulse with MC_LATENCY = 4 → exHold = stall = 1 for exactly 4 cycles, forward selects unchanged throughout; then reset asserted at cycle 2 of a second op → IDLE next edge, exHold = 0.
- branchTaken coincident with loadUse → flush = 1, stall = 0, bubble = 0, forwardA = forwardB = 0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: pipeline hazard controller for the EX stage.
// - Forwarding selects are decided while the consumer is in ID and then
//   registered, so forwardA/forwardB stay stable for the whole EX cycle.
// - Load-use hazards raise stall plus bubble for one cycle.
// - Multi-cycle EX ops (mul/div) hold the pipeline through a countdown FSM.
// - A taken branch flushes IF/ID and ID/EX.
// Optional build macro FWD_STALL_COUNT_EN adds a 32-bit saturating
// stallCount output that counts cycles with stall asserted.

module fwd_hazard_ctrl #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic        ID_useRs1,
   input  logic        ID_useRs2,
   input  logic [4:0]  EX_rd,
   input  logic        EX_regWrite,
   input  logic        EX_memRead,
   input  logic        EX_multiCycle,
   input  logic [4:0]  MEM_rd,
   input  logic        MEM_regWrite,
   input  logic        branchTaken,
   output logic [1:0]  forwardA,
   output logic [1:0]  forwardB,
   output logic        stall,
   output logic        bubble,
   output logic        exHold,
   output logic        flush
`ifdef FWD_STALL_COUNT_EN
   ,
   output logic [31:0] stallCount
`endif
);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   // Countdown starts one below the latency: the entry cycle in IDLE is
   // already the first EX cycle of the multi-cycle op.
   localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LATENCY - 1);

   localparam logic [1:0] SEL_REGFILE = 2'd0;
   localparam logic [1:0] SEL_WB      = 2'd1;
   localparam logic [1:0] SEL_MEM     = 2'd2;

   state_t           state;
   logic [CNT_W-1:0] counter;

   logic match_ex_rs1;
   logic match_ex_rs2;
   logic match_mem_rs1;
   logic match_mem_rs2;
   logic load_use;
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   // A producer matches only if it writes a non-x0 destination equal to rs.
   function automatic logic reg_match(input logic       wr,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

   // The EX producer is younger than the MEM producer, so it wins.
   function automatic logic [1:0] next_sel(input logic use_rs,
                                           input logic m_ex,
                                           input logic m_mem);
      if (use_rs && m_ex)
         return SEL_MEM;
      else if (use_rs && m_mem)
         return SEL_WB;
      else
         return SEL_REGFILE;
   endfunction

   assign match_ex_rs1  = reg_match(EX_regWrite, EX_rd, ID_rs1);
   assign match_ex_rs2  = reg_match(EX_regWrite, EX_rd, ID_rs2);
   assign match_mem_rs1 = reg_match(MEM_regWrite, MEM_rd, ID_rs1);
   assign match_mem_rs2 = reg_match(MEM_regWrite, MEM_rd, ID_rs2);

   assign load_use = EX_memRead &&
                     ((ID_useRs1 && match_ex_rs1) || (ID_useRs2 && match_ex_rs2));

   assign sel_a = next_sel(ID_useRs1, match_ex_rs1, match_mem_rs1);
   assign sel_b = next_sel(ID_useRs2, match_ex_rs2, match_mem_rs2);

   // FSM state, countdown and the registered forwarding selects.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         counter  <= '0;
         forwardA <= SEL_REGFILE;
         forwardB <= SEL_REGFILE;
      end else begin
         case (state)
            IDLE: begin
               if (branchTaken) begin
                  // ID instruction is squashed, so any load-use is moot.
                  forwardA <= SEL_REGFILE;
                  forwardB <= SEL_REGFILE;
               end else if (EX_multiCycle) begin
                  state   <= MC_BUSY;
                  counter <= MC_INIT;
               end else if (load_use) begin
                  // A bubble enters EX next cycle; it needs no forwarding.
                  forwardA <= SEL_REGFILE;
                  forwardB <= SEL_REGFILE;
               end else begin
                  forwardA <= sel_a;
                  forwardB <= sel_b;
               end
            end
            MC_BUSY: begin
               // Selects hold so the frozen EX instruction keeps its operands.
               if (counter <= CNT_W'(1)) begin
                  state   <= IDLE;
                  counter <= '0;
               end else begin
                  counter <= counter - CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               counter <= '0;
            end
         endcase
      end
   end

   // Control outputs are combinational from current inputs and state.
   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      exHold = 1'b0;
      flush  = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (branchTaken) begin
                  flush = 1'b1;
               end else if (EX_multiCycle) begin
                  exHold = 1'b1;
                  stall  = 1'b1;
               end else if (load_use) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end
            end
            MC_BUSY: begin
               exHold = 1'b1;
               stall  = 1'b1;
            end
            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

`ifdef FWD_STALL_COUNT_EN
   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset)
         stallCount <= '0;
      else if (stall && (stallCount != 32'hFFFF_FFFF))
         stallCount <= stallCount + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: the stimulus process drives one
// directed vector per cycle and queues the hand-computed outputs expected
// for that cycle; the monitor samples on the falling edge and compares.

module tb_fwd_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ID_rs1, ID_rs2, EX_rd, MEM_rd;
   logic        ID_useRs1, ID_useRs2, EX_regWrite, EX_memRead, EX_multiCycle;
   logic        MEM_regWrite, branchTaken;
   logic [1:0]  forwardA, forwardB;
   logic        stall, bubble, exHold, flush;
`ifdef FWD_STALL_COUNT_EN
   logic [31:0] stallCount;
`endif

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .ID_rs1       (ID_rs1),
      .ID_rs2       (ID_rs2),
      .ID_useRs1    (ID_useRs1),
      .ID_useRs2    (ID_useRs2),
      .EX_rd        (EX_rd),
      .EX_regWrite  (EX_regWrite),
      .EX_memRead   (EX_memRead),
      .EX_multiCycle(EX_multiCycle),
      .MEM_rd       (MEM_rd),
      .MEM_regWrite (MEM_regWrite),
      .branchTaken  (branchTaken),
      .forwardA     (forwardA),
      .forwardB     (forwardB),
      .stall        (stall),
      .bubble       (bubble),
      .exHold       (exHold),
      .flush        (flush)
`ifdef FWD_STALL_COUNT_EN
      ,
      .stallCount   (stallCount)
`endif
   );

   typedef struct {
      string       nm;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        st;
      logic        bu;
      logic        eh;
      logic        fl;
      logic [31:0] sc;
   } exp_t;

   exp_t        q[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] sc_model = 32'd0;

   // Advance to just after the next rising edge and clear all inputs.
   task automatic cyc(input logic rst);
      @(posedge clk);
      #1;
      reset         = rst;
      ID_rs1        = 5'd0;
      ID_rs2        = 5'd0;
      ID_useRs1     = 1'b0;
      ID_useRs2     = 1'b0;
      EX_rd         = 5'd0;
      EX_regWrite   = 1'b0;
      EX_memRead    = 1'b0;
      EX_multiCycle = 1'b0;
      MEM_rd        = 5'd0;
      MEM_regWrite  = 1'b0;
      branchTaken   = 1'b0;
   endtask

   // Queue the outputs expected at this cycle's falling edge.
   task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                             input logic st, input logic bu, input logic eh, input logic fl);
      exp_t e;
      e.nm = nm; e.fa = fa; e.fb = fb; e.st = st; e.bu = bu; e.eh = eh; e.fl = fl;
      e.sc = sc_model;
      q.push_back(e);
      if (reset)
         sc_model = 32'd0;
      else if (st)
         sc_model = sc_model + 32'd1;
   endtask

   // Monitor: compare every queued expectation against the sampled outputs.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t r;
         r = q.pop_front();
         total = total + 1;
         if ({forwardA, forwardB, stall, bubble, exHold, flush} !==
             {r.fa, r.fb, r.st, r.bu, r.eh, r.fl}) begin
            $display("FAIL %s: got fA=%0d fB=%0d stall=%b bubble=%b exHold=%b flush=%b, want fA=%0d fB=%0d stall=%b bubble=%b exHold=%b flush=%b",
                     r.nm, forwardA, forwardB, stall, bubble, exHold, flush,
                     r.fa, r.fb, r.st, r.bu, r.eh, r.fl);
         end
`ifdef FWD_STALL_COUNT_EN
         else if (stallCount !== r.sc) begin
            $display("FAIL %s: stallCount got %0d want %0d", r.nm, stallCount, r.sc);
         end
`endif
         else begin
            passed = passed + 1;
         end
      end
   end

   initial begin
      // Reset; stall-causing inputs must still leave controls low.
      cyc(1'b1);
      cyc(1'b1); EX_multiCycle = 1'b1; branchTaken = 1'b1;
      expect_out("reset", 2'd0, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); EX_rd = 5'd5; EX_regWrite = 1'b1; ID_rs1 = 5'd5; ID_useRs1 = 1'b1;
      expect_out("fwdA_ex_issue", 2'd0, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); MEM_rd = 5'd5; MEM_regWrite = 1'b1; EX_rd = 5'd6; EX_regWrite = 1'b1;
      ID_rs2 = 5'd5; ID_useRs2 = 1'b1;
      expect_out("fwdA_ex", 2'd2, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); EX_rd = 5'd5; EX_regWrite = 1'b1; MEM_rd = 5'd5; MEM_regWrite = 1'b1;
      ID_rs1 = 5'd5; ID_useRs1 = 1'b1;
      expect_out("fwdB_mem", 2'd0, 2'd1, 0, 0, 0, 0);

      cyc(1'b0); EX_rd = 5'd0; EX_regWrite = 1'b1; ID_rs1 = 5'd0; ID_useRs1 = 1'b1;
      expect_out("ex_wins", 2'd2, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); EX_rd = 5'd5; EX_regWrite = 1'b1; ID_rs1 = 5'd5;
      ID_rs2 = 5'd3; ID_useRs2 = 1'b1; MEM_rd = 5'd3; MEM_regWrite = 1'b1;
      expect_out("x0_no_fwd", 2'd0, 2'd0, 0, 0, 0, 0);

      // Load-use: lw x7 in EX, ID reads x7.
      cyc(1'b0); EX_rd = 5'd7; EX_regWrite = 1'b1; EX_memRead = 1'b1;
      ID_rs1 = 5'd7; ID_useRs1 = 1'b1;
      expect_out("loaduse", 2'd0, 2'd1, 1, 1, 0, 0);

      cyc(1'b0); MEM_rd = 5'd7; MEM_regWrite = 1'b1; ID_rs1 = 5'd7; ID_useRs1 = 1'b1;
      expect_out("loaduse_release", 2'd0, 2'd0, 0, 0, 0, 0);

      cyc(1'b0);
      expect_out("loaduse_fwd_wb", 2'd1, 2'd0, 0, 0, 0, 0);

      // Multi-cycle op with non-zero selects that must hold.
      cyc(1'b0); EX_rd = 5'd4; EX_regWrite = 1'b1; ID_rs1 = 5'd4; ID_useRs1 = 1'b1;
      MEM_rd = 5'd9; MEM_regWrite = 1'b1; ID_rs2 = 5'd9; ID_useRs2 = 1'b1;
      expect_out("pre_mc", 2'd0, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); EX_multiCycle = 1'b1; EX_rd = 5'd4; EX_regWrite = 1'b1;
      ID_rs2 = 5'd4; ID_useRs2 = 1'b1;
      expect_out("mc_cycle1", 2'd2, 2'd1, 1, 0, 1, 0);

      for (int i = 2; i <= 4; i++) begin
         cyc(1'b0); EX_rd = 5'd4; EX_regWrite = 1'b1; ID_rs2 = 5'd4; ID_useRs2 = 1'b1;
         branchTaken = (i == 3);
         expect_out($sformatf("mc_cycle%0d", i), 2'd2, 2'd1, 1, 0, 1, 0);
      end

      cyc(1'b0);
      expect_out("mc_done", 2'd2, 2'd1, 0, 0, 0, 0);

      // Second op, reset in its second cycle.
      cyc(1'b0); EX_multiCycle = 1'b1;
      expect_out("mc2_cycle1", 2'd0, 2'd0, 1, 0, 1, 0);

      cyc(1'b1);
      expect_out("mc2_reset", 2'd0, 2'd0, 0, 0, 0, 0);

      cyc(1'b0); EX_rd = 5'd5; EX_regWrite = 1'b1; ID_rs1 = 5'd5; ID_useRs1 = 1'b1;
      MEM_rd = 5'd6; MEM_regWrite = 1'b1; ID_rs2 = 5'd6; ID_useRs2 = 1'b1;
      expect_out("mc2_idle", 2'd0, 2'd0, 0, 0, 0, 0);

      // Branch coincident with a load-use.
      cyc(1'b0); branchTaken = 1'b1; EX_rd = 5'd7; EX_regWrite = 1'b1; EX_memRead = 1'b1;
      ID_rs1 = 5'd7; ID_useRs1 = 1'b1; ID_rs2 = 5'd7; ID_useRs2 = 1'b1;
      expect_out("branch_loaduse", 2'd2, 2'd1, 0, 0, 0, 1);

      cyc(1'b0);
      expect_out("branch_after", 2'd0, 2'd0, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() > 0) begin
         $display("FAIL drain: %0d expectations left, want 0", q.size());
         total = total + 1;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
